nf10_packet_truncator: RTL

//  Per-source-port AXI-Stream packet truncator; parametrised successor to the single-setting packet cutter.

---
 rtl/nf10_packet_truncator.sv | 118 +++++++++++
 1 files changed

// File: rtl/nf10_packet_truncator.sv
// nf10_packet_truncator: per-source-port AXI-Stream truncator that trims packets to a byte limit and drops the tail.
// Optional statistics counters are enabled by defining TRUNC_STATS_EN.
module nf10_packet_truncator #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 8,
  parameter int LEN_WIDTH          = 16
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic [NUM_PORTS-1:0]              cut_en,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]    cut_bytes,
  input  logic                              stats_clear,
  output logic [31:0]                       stat_pkts_cut,
  output logic [31:0]                       stat_bytes_drop
);
  localparam int BYTES = C_AXIS_DATA_WIDTH / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int KW    = BW + 1;
  typedef enum logic [1:0] {SOP, PASS, DROP} state_t;
  state_t                r_state;
  logic                  r_cut;
  logic [LEN_WIDTH-1:0]  r_last_idx, r_word_cnt;
  logic [KW-1:0]         r_keep;
  logic                  w_match, w_en, w_cut, w_sop, w_cut_now, w_cut_word, w_xfer;
  logic [LEN_WIDTH-1:0]  w_cb, w_cbm1, w_last_idx, w_idx, w_cnt;
  logic [KW-1:0]         w_keep, w_keep_now;
  logic [BYTES-1:0]      w_mask;
  // Lowest set source-port bit wins; iterate downward so the last hit is the lowest.
  always_comb begin
    w_match = 1'b0;
    w_en    = 1'b0;
    w_cb    = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (s_axis_tuser[16+i]) begin
        w_match = 1'b1;
        w_en    = cut_en[i];
        w_cb    = cut_bytes[i*LEN_WIDTH +: LEN_WIDTH];
      end
  end
  assign w_cbm1     = w_cb - LEN_WIDTH'(1);
  assign w_last_idx = w_cbm1 >> BW;
  assign w_keep     = {1'b0, w_cbm1[BW-1:0]} + KW'(1);
  assign w_cut      = w_match && w_en && (w_cb != '0) && (LEN_WIDTH'(s_axis_tuser[15:0]) > w_cb);
  assign w_sop      = r_state == SOP;
  assign w_cut_now  = w_sop ? w_cut : r_cut;
  assign w_idx      = w_sop ? w_last_idx : r_last_idx;
  assign w_keep_now = w_sop ? w_keep : r_keep;
  assign w_cnt      = w_sop ? '0 : r_word_cnt;
  assign w_cut_word = w_cut_now && (w_cnt == w_idx) && (r_state != DROP);
  assign w_mask     = {BYTES{1'b1}} >> (KW'(BYTES) - w_keep_now);
  assign s_axis_tready = (r_state == DROP) || m_axis_tready;
  assign m_axis_tvalid = (r_state != DROP) && s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = w_cut_word ? (s_axis_tstrb & w_mask) : s_axis_tstrb;
  assign m_axis_tlast  = s_axis_tlast || w_cut_word;
  assign w_xfer        = s_axis_tvalid && s_axis_tready;
  always_comb begin
    m_axis_tuser = s_axis_tuser;
    if (w_sop && w_cut) m_axis_tuser[15:0] = 16'(w_cb);
  end
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state    <= SOP;
      r_word_cnt <= '0;
      r_cut      <= 1'b0;
      r_last_idx <= '0;
      r_keep     <= '0;
    end else if (w_xfer) begin
      if (w_sop) begin
        r_cut      <= w_cut;
        r_last_idx <= w_last_idx;
        r_keep     <= w_keep;
      end
      if (r_state == DROP) r_state <= s_axis_tlast ? SOP : DROP;
      else if (w_cut_word) r_state <= s_axis_tlast ? SOP : DROP;
      else r_state <= s_axis_tlast ? SOP : PASS;
      r_word_cnt <= (r_state != DROP && !w_cut_word && !s_axis_tlast) ? w_cnt + LEN_WIDTH'(1) : '0;
    end
  end
`ifdef TRUNC_STATS_EN
  logic [31:0] r_pkts, r_drop, w_drop;
  // Bytes masked off the cut word count as dropped alongside whole discarded words.
  assign w_drop = (r_state == DROP) ? 32'($countones(s_axis_tstrb)) :
                  w_cut_word ? 32'($countones(s_axis_tstrb & ~w_mask)) : 32'd0;
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_pkts <= '0;
      r_drop <= '0;
    end else if (stats_clear) begin
      r_pkts <= '0;
      r_drop <= '0;
    end else if (w_xfer) begin
      if (w_sop && w_cut) r_pkts <= r_pkts + 32'd1;
      r_drop <= r_drop + w_drop;
    end
  end
  assign stat_pkts_cut   = r_pkts;
  assign stat_bytes_drop = r_drop;
`else
  logic w_unused;
  assign w_unused        = stats_clear;
  assign stat_pkts_cut   = '0;
  assign stat_bytes_drop = '0;
`endif
endmodule
